// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in, parallel-out receiver.
package sipo_pkg;

    // Receiver phase: IDLE while no bits of a word are held, SHIFT otherwise.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Word length matching the 4-bit parallel-load transmitter at the far end.
    localparam int DEFAULT_WIDTH = 4;

    // Bit-counter width; at least one bit even for the smallest legal word.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/sipo_shreg.sv
// WIDTH-bit shift register with enable, synchronous clear and selectable
// shift direction. The "shifted" output is the value the register takes on
// the next enabled edge, so the parent can capture a finished word on the
// same edge that samples its last bit.
module sipo_shreg
    import sipo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             en,
    input  logic             clear,
    input  logic             din,
    output logic [WIDTH-1:0] shifted
);

    logic [WIDTH-1:0] sr_reg;
    logic [WIDTH-1:0] base;

    // A clear in the same cycle as a shift makes the incoming bit the first
    // bit of a fresh word, so stale contents never leak into the result.
    assign base = clear ? '0 : sr_reg;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (MSB_FIRST) begin : g_msb
                if (gi == 0) begin : g_in
                    assign shifted[gi] = din;
                end else begin : g_mv
                    assign shifted[gi] = base[gi-1];
                end
            end else begin : g_lsb
                if (gi == WIDTH - 1) begin : g_in
                    assign shifted[gi] = din;
                end else begin : g_mv
                    assign shifted[gi] = base[gi+1];
                end
            end
        end
    endgenerate

    // Shift register: reset, shift on enable, otherwise optional clear.
    always_ff @(posedge clk) begin
        if (srst) begin
            sr_reg <= '0;
        end else if (en) begin
            sr_reg <= shifted;
        end else if (clear) begin
            sr_reg <= '0;
        end
    end

endmodule

// File: rtl/sipo_rx.sv
// Serial-in, parallel-out receiver: assembles WIDTH bits sampled on sft
// strobes into a word, holds it on qb with a valid/read handshake and
// reports a sticky overrun when an unread word is overwritten.
module sipo_rx
    import sipo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             sft,
    input  logic             sin,
    input  logic             sync,
    input  logic             rd,
    output logic [WIDTH-1:0] qb,
    output logic             vld,
    output logic             ovr,
    output logic             busy
);

    localparam int             CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] qb_reg;
    logic             vld_reg, vld_next;
    logic             ovr_reg, ovr_next;
    logic             complete;
    logic [WIDTH-1:0] word;

    sipo_shreg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk     (clk),
        .srst    (clr),
        .en      (sft),
        .clear   (sync),
        .din     (sin),
        .shifted (word)
    );

    // Next state, bit count and handshake flags; sync takes precedence over
    // completion because it restarts the word with the bit sampled now.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        complete   = 1'b0;
        vld_next   = vld_reg;
        ovr_next   = ovr_reg;

        if (sync) begin
            if (sft) begin
                cnt_next   = ONE;
                state_next = SHIFT;
            end else begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (sft) begin
                        cnt_next   = ONE;
                        state_next = SHIFT;
                    end
                end
                SHIFT: begin
                    if (sft) begin
                        if (cnt_reg == LAST) begin
                            complete   = 1'b1;
                            cnt_next   = '0;
                            state_next = IDLE;
                        end else begin
                            cnt_next = cnt_reg + ONE;
                        end
                    end
                end
                default: begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            endcase
        end

        // A word landing while the previous one is unread and not being
        // popped this cycle is an overrun; a pop on the same edge is not.
        if (complete) begin
            vld_next = 1'b1;
            if (vld_reg && !rd) begin
                ovr_next = 1'b1;
            end
        end else if (rd && vld_reg) begin
            vld_next = 1'b0;
        end
    end

    // State, counter and output registers; clr overrides everything.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            qb_reg    <= '0;
            vld_reg   <= 1'b0;
            ovr_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            vld_reg   <= vld_next;
            ovr_reg   <= ovr_next;
            if (complete) begin
                qb_reg <= word;
            end
        end
    end

    assign qb   = qb_reg;
    assign vld  = vld_reg;
    assign ovr  = ovr_reg;
    assign busy = (cnt_reg != '0);

endmodule

// File: doc/sipo_rx.md
Name: sipo_rx

Overview:
- Serial-in, parallel-out receiver. It is the far end of the team's 4-bit parallel-load shift-register transmitter.
- Samples one serial bit per `sft` strobe and assembles WIDTH bits into a word.
- Presents the word on `qb` with a valid/read handshake, plus a sticky overrun flag.
- Sits between the serial link and the downstream consumer that reads whole words.

Parameters:
- WIDTH, 4, word length in bits (>= 2).
- MSB_FIRST, 1:
  - 1 = first received bit lands in `qb[WIDTH-1]`.
  - 0 = first received bit lands in `qb[0]`.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- clr  input  1  synchronous, active-high reset.
- sft  input  1  bit strobe; `sin` is sampled on every rising edge where sft=1.
- sin  input  1  serial data bit.
- sync  input  1  frame resync; discards any partial word.
- rd  input  1  consumer acknowledge; pops the held word.
- qb  output  WIDTH  last completed word (held).
- vld  output  1  `qb` holds an unread word.
- ovr  output  1  sticky overrun: a word was overwritten while unread.
- busy  output  1  partial word in progress (bit count != 0).

Behaviour:
- Reset: `clr`=1 at a rising edge clears every register.
  - `qb`=0, `vld`=0, `ovr`=0, `busy`=0, internal shift register `sr`=0, bit count `cnt`=0, state=IDLE.
  - `clr` overrides all other inputs, including mid-word.
- Internal state:
  - `sr[WIDTH-1:0]`.
  - `cnt` holds 0..WIDTH-1, width $clog2(WIDTH).
  - FSM: IDLE (cnt=0) and SHIFT (0<cnt<WIDTH).
- Shift rule on sft=1:
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], sin}.
  - MSB_FIRST=0: sr <= {sin, sr[WIDTH-1:1]}.
- IDLE + sft: shift in bit, cnt<=1, go to SHIFT.
- IDLE, no sft: hold.
- SHIFT + sft, cnt<WIDTH-1: shift, cnt<=cnt+1.
- SHIFT + sft, cnt==WIDTH-1 (word completion):
  - `qb` <= fully shifted word on the same edge.
  - `vld`<=1, cnt<=0, go to IDLE.
  - Latency: word visible on `qb` the cycle after the edge that sampled its last bit.
- SHIFT, no sft: hold; there is no timeout.
- Gaps: sft may drop between bits; the receiver simply waits.
- sync=1 (not clr):
  - Discards sr/cnt contents.
  - sft=0 in the same cycle: cnt<=0, sr<=0, go to IDLE.
  - sft=1 in the same cycle: the sampled bit is the first bit of a new word, cnt<=1, go to SHIFT.
  - `qb`, `vld` and `ovr` are unaffected.
- Read handshake:
  - `rd`=1 while `vld`=1 clears `vld` next edge.
  - `rd` while `vld`=0 is ignored.
  - `qb` keeps its value after the read.
- Simultaneous completion and rd with `vld`=1: new word loads, `vld` stays 1, no overrun.
- Completion with `vld`=1 and rd=0:
  - New word overwrites `qb`, `vld` stays 1.
  - `ovr`<=1; it stays 1 until `clr`.
- busy = (cnt != 0), registered-derived; no combinational path from inputs.
- `sin` is ignored when sft=0.
- WIDTH=1 is not supported.

Decomposition:
- Shared package `sipo_pkg`:
  - State enumeration (IDLE, SHIFT).
  - Default WIDTH constant (4).
  - Localparam for counter width.
- One natural sub-module: `sipo_shreg`, the WIDTH-bit shift register with enable, sync-clear and MSB_FIRST direction.
- FSM, counter and handshake stay in the top.

Test Plan:
- Reset: clr=1 for 2 cycles with sft=1, sin=1 -> qb=0, vld=0, ovr=0, busy=0 throughout. After release, busy rises only on the first sft.
- Basic word, MSB_FIRST=1:
  - Stimulus: sft=1 for 4 cycles, sin=1,0,1,1.
  - Response: qb=4'b1011, vld=1 one cycle after the 4th sampling edge; busy=1 after bits 1-3, 0 after bit 4.
  - Then rd=1 for one cycle -> vld=0, qb stays 4'b1011.
- Gapped strobes and LSB-first: MSB_FIRST=0, bits 1,1,0,0 with sft low 2 cycles between each -> qb=4'b0011, vld=1 only after the 4th strobe.
- Resync mid-word:
  - Stimulus: send 1,1 then sync=1 with sft=1, sin=0, then 1,1,0.
  - Response: qb=4'b0110, the first two bits are discarded, and `qb`/`vld` from any earlier word are unchanged until completion.
- Overrun without read:
  - Stimulus: receive 4'b1011, no rd, then receive 4'b0101.
  - Response: qb=4'b0101, vld=1, ovr=1; ovr stays 1 after rd until clr.
- Read at completion: rd=1 on the same edge that completes 4'b1110 while vld=1 -> qb=4'b1110, vld=1, ovr=0. Assert clr mid-word (cnt=2) -> all outputs 0 next cycle.
